// File: rtl/uart_pkg.sv
// Shared command codes, FSM states and address constants for the DMI UART TAP.
// The header byte is {cmd, addr}; IRLENGTH sets the address field width.
package uart_pkg;

  localparam int IRLENGTH = 5;
  localparam logic [IRLENGTH-1:0] ADDR_IDCODE = 5'h01;

  typedef enum logic [2:0] {
    CMD_NOP        = 3'd0,
    CMD_READ       = 3'd1,
    CMD_WRITE      = 3'd2,
    CMD_CONT_READ  = 3'd3,
    CMD_CONT_WRITE = 3'd4,
    CMD_BURST_READ = 3'd5,
    CMD_RESET      = 3'd6,
    CMD_ERROR      = 3'd7
  } cmd_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DECODE,
    ST_COUNT,
    ST_RX_DATA,
    ST_WR_REQ,
    ST_RD_REQ,
    ST_TX_DATA,
    ST_SEND_CMD
  } tap_state_t;

endpackage

// File: rtl/uart_tap_word_buf.sv
// Byte-lane shift buffer holding one DMI word; bytes enter and leave LSB first.
// Lanes above WIDTH-1 are zero-filled on load, so padding bits go out as 0.
module uart_tap_word_buf #(
  parameter int WIDTH  = 41,
  parameter int NBYTES = (WIDTH + 7) / 8
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             shift_in,
  input  logic [7:0]       in_byte,
  input  logic             shift_out,
  input  logic             clr_idx,
  output logic [WIDTH-1:0] word,
  output logic [7:0]       out_byte,
  output logic             last
);

  localparam int IDXW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  logic [NBYTES-1:0][7:0] data_reg, data_next;
  logic [NBYTES*8-1:0]    load_ext;
  logic [NBYTES*8-1:0]    flat;
  logic [IDXW-1:0]        idx_reg;

  assign load_ext = (NBYTES*8)'(load_data);

  // Each lane takes its upper neighbour on a shift; the top lane takes the
  // incoming byte (rx) or zero (tx).
  for (genvar gi = 0; gi < NBYTES; gi++) begin : g_lane
    logic [7:0] upper;
    if (gi == NBYTES - 1) begin : g_top
      assign upper = shift_in ? in_byte : 8'h00;
    end else begin : g_mid
      assign upper = data_reg[gi+1];
    end
    assign data_next[gi] = load ? load_ext[gi*8 +: 8] :
                           (shift_in || shift_out) ? upper : data_reg[gi];
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      data_reg <= '0;
      idx_reg  <= '0;
    end else begin
      data_reg <= data_next;
      if (load || clr_idx)
        idx_reg <= '0;
      else if (shift_in || shift_out)
        idx_reg <= last ? '0 : idx_reg + 1'b1;
    end
  end

  assign last     = (idx_reg == IDXW'(NBYTES - 1));
  assign flat     = data_reg;
  assign word     = flat[WIDTH-1:0];
  assign out_byte = data_reg[0];

endmodule

// File: rtl/dmi_uart_tap_burst.sv
// UART-to-DMI command decoder: single/continuous/burst reads, single/continuous
// writes, hard reset and error status bytes returned on the command channel.
module dmi_uart_tap_burst
  import uart_pkg::*;
#(
  parameter int WIDTH = 41,
  parameter int IRLEN = IRLENGTH,
  parameter int NADDR = 2**IRLEN
) (
  input  logic             CLK_I,
  input  logic             RST_I,
  output logic             READ_O,
  input  logic [7:0]       DATA_REC_I,
  input  logic             RX_EMPTY_I,
  input  logic             CMD_REC_I,
  input  logic             TX_READY_I,
  output logic             WRITE_O,
  output logic [7:0]       DATA_SEND_O,
  output logic             SEND_COMMAND_O,
  output logic [7:0]       COMMAND_O,
  output logic             DMI_HARD_RESET_O,
  input  logic [1:0]       DMI_ERROR_I,
  output logic [IRLEN-1:0] WRITE_ADDRESS_O,
  output logic [WIDTH-1:0] WRITE_DATA_O,
  output logic             WRITE_VALID_O,
  input  logic             WRITE_READY_I,
  output logic [IRLEN-1:0] READ_ADDRESS_O,
  input  logic [WIDTH-1:0] READ_DATA_I,
  input  logic             READ_VALID_I,
  output logic             READ_READY_O,
  input  logic [NADDR-1:0] VALID_ADDRESS_I
);

  localparam int NBYTES = (WIDTH + 7) / 8;

  tap_state_t       state_reg, state_next;
  cmd_t             cmd_reg, cmd_next;
  logic [IRLEN-1:0] addr_reg, addr_next;
  logic [7:0]       count_reg, count_next;
  logic             unlim_reg, unlim_next;
  logic [1:0]       err_reg, err_next;
  logic [7:0]       status_reg, status_next;

  logic             buf_load, buf_shift_in, buf_shift_out, buf_clr, buf_last;
  logic [WIDTH-1:0] buf_word;
  logic [7:0]       buf_byte;
  logic             rx_avail;
  cmd_t             rx_cmd;

  assign rx_avail = !RX_EMPTY_I;
  assign rx_cmd   = cmd_t'(DATA_REC_I[7:IRLEN]);

  uart_tap_word_buf #(.WIDTH(WIDTH), .NBYTES(NBYTES)) u_word_buf (
    .clk       (CLK_I),
    .srst      (RST_I),
    .load      (buf_load),
    .load_data (READ_DATA_I),
    .shift_in  (buf_shift_in),
    .in_byte   (DATA_REC_I),
    .shift_out (buf_shift_out),
    .clr_idx   (buf_clr),
    .word      (buf_word),
    .out_byte  (buf_byte),
    .last      (buf_last)
  );

  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      state_reg  <= ST_IDLE;
      cmd_reg    <= CMD_NOP;
      addr_reg   <= '0;
      count_reg  <= '0;
      unlim_reg  <= 1'b0;
      err_reg    <= '0;
      status_reg <= '0;
    end else begin
      state_reg  <= state_next;
      cmd_reg    <= cmd_next;
      addr_reg   <= addr_next;
      count_reg  <= count_next;
      unlim_reg  <= unlim_next;
      err_reg    <= err_next;
      status_reg <= status_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    cmd_next         = cmd_reg;
    addr_next        = addr_reg;
    count_next       = count_reg;
    unlim_next       = unlim_reg;
    err_next         = err_reg;
    status_next      = status_reg;
    READ_O           = 1'b0;
    WRITE_O          = 1'b0;
    SEND_COMMAND_O   = 1'b0;
    DMI_HARD_RESET_O = 1'b0;
    WRITE_VALID_O    = 1'b0;
    READ_READY_O     = 1'b0;
    buf_load         = 1'b0;
    buf_shift_in     = 1'b0;
    buf_shift_out    = 1'b0;
    buf_clr          = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (rx_avail) begin
          READ_O = 1'b1;
          if (CMD_REC_I) begin
            cmd_next   = rx_cmd;
            addr_next  = DATA_REC_I[IRLEN-1:0];
            state_next = ST_DECODE;
          end
        end
      end
      ST_DECODE: begin
        err_next = '0;
        if (cmd_reg == CMD_RESET) begin
          DMI_HARD_RESET_O = 1'b1;
          state_next       = ST_IDLE;
        end else if (!VALID_ADDRESS_I[addr_reg]) begin
          status_next = {CMD_ERROR, addr_reg};
          state_next  = ST_SEND_CMD;
        end else begin
          case (cmd_reg)
            CMD_READ:       begin count_next = 8'd1; unlim_next = 1'b0; state_next = ST_RD_REQ; end
            CMD_CONT_READ:  begin unlim_next = 1'b1; state_next = ST_RD_REQ; end
            CMD_BURST_READ: state_next = ST_COUNT;
            CMD_WRITE, CMD_CONT_WRITE: begin buf_clr = 1'b1; state_next = ST_RX_DATA; end
            default:        state_next = ST_IDLE;
          endcase
        end
      end
      ST_COUNT: begin
        if (rx_avail) begin
          READ_O = 1'b1;
          if (CMD_REC_I) begin
            cmd_next   = rx_cmd;
            addr_next  = DATA_REC_I[IRLEN-1:0];
            state_next = ST_DECODE;
          end else if (DATA_REC_I == 8'd0) begin
            state_next = ST_IDLE;
          end else begin
            count_next = DATA_REC_I;
            unlim_next = 1'b0;
            state_next = ST_RD_REQ;
          end
        end
      end
      ST_RX_DATA: begin
        if (rx_avail) begin
          READ_O = 1'b1;
          if (CMD_REC_I) begin
            // A header mid-word drops the partial word and starts a new command.
            buf_clr    = 1'b1;
            cmd_next   = rx_cmd;
            addr_next  = DATA_REC_I[IRLEN-1:0];
            state_next = ST_DECODE;
          end else begin
            buf_shift_in = 1'b1;
            if (buf_last) state_next = ST_WR_REQ;
          end
        end
      end
      ST_WR_REQ: begin
        WRITE_VALID_O = 1'b1;
        if (WRITE_READY_I) begin
          if (DMI_ERROR_I != 2'b00) begin
            status_next = {CMD_ERROR, 3'b000, DMI_ERROR_I};
            state_next  = ST_SEND_CMD;
          end else if (cmd_reg == CMD_CONT_WRITE) begin
            state_next = ST_RX_DATA;
          end else begin
            state_next = ST_IDLE;
          end
        end
      end
      ST_RD_REQ: begin
        READ_READY_O = 1'b1;
        if (READ_VALID_I) begin
          buf_load   = 1'b1;
          err_next   = DMI_ERROR_I;
          state_next = ST_TX_DATA;
        end
      end
      ST_TX_DATA: begin
        if (TX_READY_I) begin
          WRITE_O       = 1'b1;
          buf_shift_out = 1'b1;
          if (buf_last) begin
            if (err_reg != 2'b00) begin
              status_next = {CMD_ERROR, 3'b000, err_reg};
              state_next  = ST_SEND_CMD;
            end else if (!unlim_reg && count_reg == 8'd1) begin
              count_next = 8'd0;
              state_next = ST_IDLE;
            end else begin
              if (!unlim_reg) count_next = count_reg - 8'd1;
              // A pending header ends the stream; IDLE pops and decodes it.
              state_next = (rx_avail && CMD_REC_I) ? ST_IDLE : ST_RD_REQ;
            end
          end
        end
      end
      ST_SEND_CMD: begin
        SEND_COMMAND_O = 1'b1;
        if (TX_READY_I) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign COMMAND_O       = (state_reg == ST_SEND_CMD) ? status_reg : 8'h00;
  assign DATA_SEND_O     = (state_reg == ST_TX_DATA) ? buf_byte : 8'h00;
  assign WRITE_ADDRESS_O = addr_reg;
  assign READ_ADDRESS_O  = addr_reg;
  assign WRITE_DATA_O    = buf_word;

endmodule

// File: tb/tb_dmi_uart_tap_burst.sv
// Directed bench for dmi_uart_tap_burst: a vector table of single reads/writes
// plus hand-written burst, continuous, abort, error and reset sequences.
module tb_dmi_uart_tap_burst;
  import uart_pkg::*;

  logic        CLK_I = 1'b0;
  logic        RST_I;
  logic        READ_O;
  logic [7:0]  DATA_REC_I;
  logic        RX_EMPTY_I;
  logic        CMD_REC_I;
  logic        TX_READY_I;
  logic        WRITE_O;
  logic [7:0]  DATA_SEND_O;
  logic        SEND_COMMAND_O;
  logic [7:0]  COMMAND_O;
  logic        DMI_HARD_RESET_O;
  logic [1:0]  DMI_ERROR_I;
  logic [4:0]  WRITE_ADDRESS_O;
  logic [40:0] WRITE_DATA_O;
  logic        WRITE_VALID_O;
  logic        WRITE_READY_I;
  logic [4:0]  READ_ADDRESS_O;
  logic [40:0] READ_DATA_I;
  logic        READ_VALID_I;
  logic        READ_READY_O;
  logic [31:0] VALID_ADDRESS_I;

  dmi_uart_tap_burst #(.WIDTH(41), .IRLEN(5), .NADDR(32)) dut (
    .CLK_I(CLK_I), .RST_I(RST_I), .READ_O(READ_O), .DATA_REC_I(DATA_REC_I),
    .RX_EMPTY_I(RX_EMPTY_I), .CMD_REC_I(CMD_REC_I), .TX_READY_I(TX_READY_I),
    .WRITE_O(WRITE_O), .DATA_SEND_O(DATA_SEND_O), .SEND_COMMAND_O(SEND_COMMAND_O),
    .COMMAND_O(COMMAND_O), .DMI_HARD_RESET_O(DMI_HARD_RESET_O), .DMI_ERROR_I(DMI_ERROR_I),
    .WRITE_ADDRESS_O(WRITE_ADDRESS_O), .WRITE_DATA_O(WRITE_DATA_O),
    .WRITE_VALID_O(WRITE_VALID_O), .WRITE_READY_I(WRITE_READY_I),
    .READ_ADDRESS_O(READ_ADDRESS_O), .READ_DATA_I(READ_DATA_I),
    .READ_VALID_I(READ_VALID_I), .READ_READY_O(READ_READY_O),
    .VALID_ADDRESS_I(VALID_ADDRESS_I)
  );

  always #5 CLK_I = ~CLK_I;

  typedef struct {
    bit          is_write;
    logic [4:0]  addr;
    logic [47:0] stream;  // tx bytes expected (read) or rx payload (write), byte0 in [7:0]
    logic [40:0] word;    // read data supplied (read) or write data expected (write)
  } vec_t;

  vec_t        vecs[6];
  logic [7:0]  exp_burst[18] = '{8'h0E, 8'h0D, 8'h0C, 8'h0B, 8'h0A, 8'h01,
                                 8'h15, 8'h14, 8'h13, 8'h12, 8'h11, 8'h00,
                                 8'hB4, 8'hC3, 8'hD2, 8'hE1, 8'hF0, 8'h00};

  // Stimulus queues are filled by the test and consumed through pointers owned by the driver.
  logic [8:0]  rx_q[$];
  logic [40:0] rd_q[$];
  int          rx_ptr = 0, rd_ptr = 0;
  int          tx_mode = 0;  // 0: always ready, 1: toggling, 2: stalled

  logic [7:0]  tx_log[$];
  logic [7:0]  cmd_log[$];
  logic [40:0] wr_data_log[$];
  logic [4:0]  wr_addr_log[$];
  logic [4:0]  rd_addr_log[$];
  int          rd_hs = 0, hr_cnt = 0, stab_err = 0, wo_viol = 0;
  int          cyc = 0, last_pop_cyc = 0, rr_rise_cyc = 0, wv_rise_cyc = 0;
  bit          do_pop = 0, do_rd_hs = 0, rr_prev = 0, wv_prev = 0, wacc_prev = 0;
  logic [40:0] wd_prev = '0;
  logic [4:0]  wa_prev = '0;

  int n_cmp = 0;
  int n_fail = 0;

  // Driver: applies the next rx byte, read word and handshake inputs after each edge.
  initial begin
    RX_EMPTY_I = 1'b1; DATA_REC_I = 8'h00; CMD_REC_I = 1'b0; TX_READY_I = 1'b1;
    WRITE_READY_I = 1'b0; READ_VALID_I = 1'b0; READ_DATA_I = '0;
    forever begin
      @(posedge CLK_I);
      #1;
      if (do_pop) rx_ptr++;
      if (do_rd_hs) rd_ptr++;
      RX_EMPTY_I = (rx_ptr >= rx_q.size());
      {CMD_REC_I, DATA_REC_I} = RX_EMPTY_I ? 9'h000 : rx_q[rx_ptr];
      READ_DATA_I = (rd_ptr < rd_q.size()) ? rd_q[rd_ptr] : '0;
      case (tx_mode)
        0:       TX_READY_I = 1'b1;
        1:       TX_READY_I = ~TX_READY_I;
        default: TX_READY_I = 1'b0;
      endcase
      WRITE_READY_I = 1'($urandom_range(0, 1));
      READ_VALID_I  = 1'($urandom_range(0, 1));
    end
  end

  // Monitor: logs every transaction seen on the opposite clock edge.
  initial begin
    forever begin
      @(negedge CLK_I);
      cyc++;
      do_pop = READ_O;
      if (READ_O) last_pop_cyc = cyc;
      if (WRITE_O) tx_log.push_back(DATA_SEND_O);
      if (WRITE_O && !TX_READY_I) wo_viol++;
      if (SEND_COMMAND_O && TX_READY_I) cmd_log.push_back(COMMAND_O);
      if (DMI_HARD_RESET_O) hr_cnt++;
      if (READ_READY_O && !rr_prev) rr_rise_cyc = cyc;
      rr_prev = READ_READY_O;
      do_rd_hs = READ_READY_O && READ_VALID_I;
      if (do_rd_hs) begin
        rd_hs++;
        rd_addr_log.push_back(READ_ADDRESS_O);
      end
      if (WRITE_VALID_O) begin
        if (wv_prev && !wacc_prev && (WRITE_DATA_O !== wd_prev || WRITE_ADDRESS_O !== wa_prev))
          stab_err++;
        if (!wv_prev) wv_rise_cyc = cyc;
        if (WRITE_READY_I) begin
          wr_data_log.push_back(WRITE_DATA_O);
          wr_addr_log.push_back(WRITE_ADDRESS_O);
        end
      end
      wv_prev   = WRITE_VALID_O;
      wacc_prev = WRITE_VALID_O && WRITE_READY_I;
      wd_prev   = WRITE_DATA_O;
      wa_prev   = WRITE_ADDRESS_O;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_hdr(input cmd_t c, input logic [4:0] a);
    rx_q.push_back({1'b1, c, a});
  endtask

  task automatic push_byte(input logic [7:0] b);
    rx_q.push_back({1'b0, b});
  endtask

  task automatic run(input int n);
    repeat (n) @(negedge CLK_I);
  endtask

  function automatic logic [47:0] tx_stream(input int base);
    logic [47:0] s = '0;
    for (int k = 0; k < 6; k++)
      if (base + k < tx_log.size()) s[8*k +: 8] = tx_log[base + k];
    return s;
  endfunction

  initial begin
    int tb0, hs0, w0, c0, h0;

    vecs[0] = '{1'b0, ADDR_IDCODE, 48'h01_23_45_67_89_AB, 41'h1_2345_6789_AB};
    vecs[1] = '{1'b0, 5'h10,       48'h00_FF_FF_00_00_5A, 41'h0_FFFF_0000_5A};
    vecs[2] = '{1'b0, 5'h1F,       48'h01_FF_FF_FF_FF_FF, 41'h1_FFFF_FFFF_FF};
    vecs[3] = '{1'b1, 5'h04,       48'h06_05_04_03_02_01, 41'h0_0504_0302_01};
    vecs[4] = '{1'b1, 5'h10,       48'hFF_DE_AD_BE_EF_00, 41'h1_DEAD_BEEF_00};
    vecs[5] = '{1'b1, 5'h1E,       48'hFE_11_22_33_44_55, 41'h0_1122_3344_55};

    RST_I = 1'b1;
    DMI_ERROR_I = 2'b00;
    VALID_ADDRESS_I = 32'hFFFF_FF7F;  // address 7 unimplemented
    run(4);
    RST_I = 1'b0;
    run(1);
    check("rst_ctrl", {READ_O, WRITE_O, SEND_COMMAND_O, DMI_HARD_RESET_O, WRITE_VALID_O, READ_READY_O}, 0);
    check("rst_bytes", {DATA_SEND_O, COMMAND_O}, 0);
    check("rst_wdata", WRITE_DATA_O, 0);
    check("rst_addr", {WRITE_ADDRESS_O, READ_ADDRESS_O}, 0);

    for (int i = 0; i < 6; i++) begin
      tb0 = tx_log.size(); hs0 = rd_hs; w0 = wr_data_log.size();
      if (!vecs[i].is_write) begin
        rd_q.push_back(vecs[i].word);
        push_hdr(CMD_READ, vecs[i].addr);
        run(25);
        check($sformatf("v%0d_rd_hs", i), rd_hs - hs0, 1);
        check($sformatf("v%0d_tx_cnt", i), tx_log.size() - tb0, 6);
        check($sformatf("v%0d_tx_bytes", i), tx_stream(tb0), vecs[i].stream);
        check($sformatf("v%0d_rd_addr", i), rd_addr_log[rd_addr_log.size()-1], vecs[i].addr);
        check($sformatf("v%0d_rd_latency", i), rr_rise_cyc - last_pop_cyc, 2);
      end else begin
        push_hdr(CMD_WRITE, vecs[i].addr);
        for (int k = 0; k < 6; k++) push_byte(vecs[i].stream[8*k +: 8]);
        run(25);
        check($sformatf("v%0d_wr_cnt", i), wr_data_log.size() - w0, 1);
        if (wr_data_log.size() > w0) begin
          check($sformatf("v%0d_wr_data", i), wr_data_log[w0], vecs[i].word);
          check($sformatf("v%0d_wr_addr", i), wr_addr_log[w0], vecs[i].addr);
        end
        check($sformatf("v%0d_wr_latency", i), wv_rise_cyc - last_pop_cyc, 1);
      end
    end

    // Burst of three with TX_READY_I toggling.
    tx_mode = 1;
    tb0 = tx_log.size(); hs0 = rd_hs;
    rd_q.push_back(41'h1_0A0B_0C0D_0E);
    rd_q.push_back(41'h0_1112_1314_15);
    rd_q.push_back(41'h0_F0E1_D2C3_B4);
    push_hdr(CMD_BURST_READ, 5'h02);
    push_byte(8'd3);
    run(120);
    check("burst_hs", rd_hs - hs0, 3);
    check("burst_tx_cnt", tx_log.size() - tb0, 18);
    for (int k = 0; k < 18; k++)
      if (tb0 + k < tx_log.size())
        check($sformatf("burst_byte%0d", k), tx_log[tb0 + k], exp_burst[k]);

    // Burst count of zero: no DMI access, count byte consumed.
    tx_mode = 0;
    hs0 = rd_hs;
    push_hdr(CMD_BURST_READ, 5'h02);
    push_byte(8'd0);
    run(15);
    check("burst0_hs", rd_hs - hs0, 0);
    check("burst0_drained", rx_q.size() - rx_ptr, 0);

    // Continuous write of two words, terminated by a NOP header.
    w0 = wr_data_log.size();
    push_hdr(CMD_CONT_WRITE, 5'h05);
    for (int k = 1; k <= 12; k++) push_byte(8'(k));
    push_hdr(CMD_NOP, 5'h05);
    run(60);
    check("cw_cnt", wr_data_log.size() - w0, 2);
    if (wr_data_log.size() >= w0 + 2) begin
      check("cw_word0", wr_data_log[w0], 41'h0_0504_0302_01);
      check("cw_word1", wr_data_log[w0+1], 41'h0_0B0A_0908_07);
      check("cw_addr1", wr_addr_log[w0+1], 5'h05);
    end
    check("wr_stable", stab_err, 0);

    // Header after three payload bytes aborts the write and runs the new read.
    w0 = wr_data_log.size(); hs0 = rd_hs; tb0 = tx_log.size();
    rd_q.push_back(41'h0_CAFE_F00D_42);
    push_hdr(CMD_WRITE, 5'h03);
    push_byte(8'hAA); push_byte(8'hBB); push_byte(8'hCC);
    push_hdr(CMD_READ, 5'h03);
    run(30);
    check("abort_no_wr", wr_data_log.size() - w0, 0);
    check("abort_rd_hs", rd_hs - hs0, 1);
    check("abort_tx", tx_stream(tb0), 48'h00_CA_FE_F0_0D_42);

    // Unimplemented address reports an error with the address, no DMI access.
    tx_mode = 1;
    hs0 = rd_hs; c0 = cmd_log.size();
    push_hdr(CMD_READ, 5'h07);
    run(15);
    check("inval_no_rd", rd_hs - hs0, 0);
    check("inval_cmd_cnt", cmd_log.size() - c0, 1);
    if (cmd_log.size() > c0) check("inval_cmd", cmd_log[c0], 8'hE7);

    // DMI error during a continuous read ends the stream with an error status.
    tx_mode = 0;
    hs0 = rd_hs; c0 = cmd_log.size(); tb0 = tx_log.size();
    DMI_ERROR_I = 2'b10;
    rd_q.push_back(41'h0_0000_0000_55);
    push_hdr(CMD_CONT_READ, 5'h01);
    run(40);
    DMI_ERROR_I = 2'b00;
    check("err_rd_hs", rd_hs - hs0, 1);
    check("err_tx", tx_stream(tb0), 48'h00_00_00_00_00_55);
    check("err_cmd_cnt", cmd_log.size() - c0, 1);
    if (cmd_log.size() > c0) check("err_cmd", cmd_log[c0], 8'hE2);

    // Hard reset command pulses once, even on an unimplemented address.
    h0 = hr_cnt; c0 = cmd_log.size(); hs0 = rd_hs;
    push_hdr(CMD_RESET, 5'h07);
    run(10);
    check("hreset_pulse", hr_cnt - h0, 1);
    check("hreset_no_cmd", cmd_log.size() - c0, 0);

    // Reset while stalled in the transmit phase.
    tx_mode = 2;
    tb0 = tx_log.size(); hs0 = rd_hs;
    rd_q.push_back(41'h1_1111_1111_11);
    push_hdr(CMD_READ, 5'h01);
    run(10);
    check("stall_no_tx", WRITE_O, 0);
    RST_I = 1'b1;
    run(1);
    check("midrst_ctrl", {READ_O, WRITE_O, SEND_COMMAND_O, DMI_HARD_RESET_O, WRITE_VALID_O, READ_READY_O}, 0);
    check("midrst_bytes", {DATA_SEND_O, COMMAND_O}, 0);
    check("midrst_wdata", WRITE_DATA_O, 0);
    RST_I = 1'b0;
    tx_mode = 0;
    run(15);
    check("midrst_tx_dropped", tx_log.size() - tb0, 0);
    check("midrst_rd_hs", rd_hs - hs0, 1);
    tb0 = tx_log.size();
    rd_q.push_back(41'h0_0000_0000_A5);
    push_hdr(CMD_READ, 5'h01);
    run(25);
    check("postrst_tx", tx_stream(tb0), 48'h00_00_00_00_00_A5);

    check("write_o_only_when_ready", wo_viol, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
